control_unit: RTL

//  Hardwired Moore control sequencer for the 32-bit bus CPU. It drives every control input of the datapath
//  (register in/out strobes, Gra/Grb/Grc, ALU op selects, memory read/write, port strobes).
//  It steps fetch -> decode -> execute from IR[31:27] and the datapath CON_FF result.
//  It sits beside the datapath in the CPU top level and is the producer for every datapath control line.

---
 rtl/cpu_ctrl_pkg.sv | 111 +++++++++++
 rtl/control_unit_if.sv | 43 ++++
 rtl/ctrl_op_decode.sv | 50 +++++
 rtl/control_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the hardwired control sequencer of the 32-bit bus CPU:
// opcode values from ir[31:27], the sequencer state encoding, the operation
// classes produced by the opcode decoder, the one-hot ALU select bundle, and the
// bundle of every datapath control line that control_unit drives.
// No ports (package).

package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_MEM,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_BR,
    CLS_JUMP,
    CLS_IO,
    CLS_NOP,
    CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic and_op;
    logic or_op;
    logic add_op;
    logic sub_op;
    logic mul_op;
    logic div_op;
    logic shr_op;
    logic shl_op;
    logic ror_op;
    logic rol_op;
    logic neg_op;
    logic not_op;
  } alu_sel_t;

  typedef struct packed {
    logic     dp_clear;
    logic     run;
    logic     PCout;
    logic     MDRout;
    logic     HIout;
    logic     LOout;
    logic     Zhighout;
    logic     Zlowout;
    logic     Inportout;
    logic     Cout;
    logic     BAout;
    logic     PCin;
    logic     IRin;
    logic     MARin;
    logic     Yin;
    logic     HIin;
    logic     LOin;
    logic     Zin;
    logic     MDRin;
    logic     Rin;
    logic     Rout;
    logic     OutPort;
    logic     Gra;
    logic     Grb;
    logic     Grc;
    alu_sel_t alu;
    logic     IncPC;
    logic     read;
    logic     write;
  } ctl_t;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if
// Bundle between the control sequencer and the datapath.
//   ir, con_ff, stop : datapath/system -> controller (IR, branch condition, halt request)
//   dp_clear, run    : controller status / datapath clear
//   bus sources      : PCout MDRout HIout LOout Zhighout Zlowout Inportout Cout BAout
//   load strobes     : PCin IRin MARin Yin HIin LOin Zin MDRin Rin Rout OutPort
//   field selects    : Gra Grb Grc
//   ALU ops          : AND OR ADD SUB MUL DIV SHR SHL ROR ROL NEG NOT IncPC
//   RAM strobes      : read write
// Modport master is the controller side, slave the datapath side.

interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;

  logic dp_clear, run;
  logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout, Cout, BAout;
  logic PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Rin, Rout, OutPort;
  logic Gra, Grb, Grc;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic read, write;

  modport master (
    input  ir, con_ff, stop,
    output dp_clear, run,
    output PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout, Cout, BAout,
    output PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Rin, Rout, OutPort,
    output Gra, Grb, Grc,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    output read, write
  );

  modport slave (
    output ir, con_ff, stop,
    input  dp_clear, run,
    input  PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout, Cout, BAout,
    input  PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Rin, Rout, OutPort,
    input  Gra, Grb, Grc,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    input  read, write
  );
endinterface

// File: rtl/ctrl_op_decode.sv
// ctrl_op_decode
// Combinational opcode decoder: ir[31:27] -> operation class plus the one-hot
// ALU select used by the arithmetic step of that class.
//   i_opcode : ir[31:27]
//   o_class  : operation class (drives the sequencer's step selection)
//   o_alu    : one-hot ALU op (all zero for classes that pick ADD themselves)
// Build option CTRL_MULDIV_EN: when undefined, mul/div decode as nop so the
// multiplier/divider strobes can never be reached.

module ctrl_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output op_class_t  o_class,
  output alu_sel_t   o_alu
);

  always_comb begin
    o_class = CLS_NOP;
    o_alu   = '0;
    case (i_opcode)
      OP_LD, OP_LDI, OP_ST: o_class = CLS_MEM;
      OP_ADD:  begin o_class = CLS_RTYPE; o_alu.add_op = 1'b1; end
      OP_SUB:  begin o_class = CLS_RTYPE; o_alu.sub_op = 1'b1; end
      OP_AND:  begin o_class = CLS_RTYPE; o_alu.and_op = 1'b1; end
      OP_OR:   begin o_class = CLS_RTYPE; o_alu.or_op  = 1'b1; end
      OP_SHR:  begin o_class = CLS_RTYPE; o_alu.shr_op = 1'b1; end
      OP_SHL:  begin o_class = CLS_RTYPE; o_alu.shl_op = 1'b1; end
      OP_ROR:  begin o_class = CLS_RTYPE; o_alu.ror_op = 1'b1; end
      OP_ROL:  begin o_class = CLS_RTYPE; o_alu.rol_op = 1'b1; end
      OP_ADDI: begin o_class = CLS_ITYPE; o_alu.add_op = 1'b1; end
      OP_ANDI: begin o_class = CLS_ITYPE; o_alu.and_op = 1'b1; end
      OP_ORI:  begin o_class = CLS_ITYPE; o_alu.or_op  = 1'b1; end
`ifdef CTRL_MULDIV_EN
      OP_MUL:  begin o_class = CLS_MULDIV; o_alu.mul_op = 1'b1; end
      OP_DIV:  begin o_class = CLS_MULDIV; o_alu.div_op = 1'b1; end
`else
      OP_MUL, OP_DIV: o_class = CLS_NOP;
`endif
      OP_NEG:  begin o_class = CLS_UNARY; o_alu.neg_op = 1'b1; end
      OP_NOT:  begin o_class = CLS_UNARY; o_alu.not_op = 1'b1; end
      OP_BR:   o_class = CLS_BR;
      OP_JR, OP_JAL: o_class = CLS_JUMP;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO: o_class = CLS_IO;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Hardwired Moore sequencer for the 32-bit bus CPU: fetch -> decode -> execute,
// driving every datapath control line from the registered state and the IR.
//   clk    : system clock, rising edge
//   clear  : asynchronous active-low reset (forces RST, all outputs 0)
//   bus    : control_unit_if.master (ir/con_ff/stop in, all control lines out)
// Parameter MEM_WAIT (0..7): extra cycles FETCH1, ld T6 and st T7 are held.
// Build option CTRL_MULDIV_EN enables the mul/div sequences (see ctrl_op_decode).

module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
)(
  input  logic           clk,
  input  logic           clear,
  control_unit_if.master bus
);

  state_t    r_state;
  state_t    w_next;
  logic [2:0] r_wait;
  logic [4:0] w_op;
  op_class_t w_class;
  alu_sel_t  w_alu;
  logic      w_isLd, w_isSt, w_isLdi, w_isJal;
  logic      w_memState, w_waitDone;
  ctl_t      w_ctl;

  assign w_op    = bus.ir[31:27];
  assign w_isLd  = (w_op == OP_LD);
  assign w_isSt  = (w_op == OP_ST);
  assign w_isLdi = (w_op == OP_LDI);
  assign w_isJal = (w_op == OP_JAL);

  ctrl_op_decode u_decode (
    .i_opcode (w_op),
    .o_class  (w_class),
    .o_alu    (w_alu)
  );

  // States that talk to slow RAM stay put until the wait counter reaches MEM_WAIT
  assign w_memState = (r_state == ST_FETCH1) ||
                      (r_state == ST_T6 && w_isLd) ||
                      (r_state == ST_T7 && w_isSt);
  assign w_waitDone = (r_wait == 3'(MEM_WAIT));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= ST_RST;
    else        r_state <= w_next;
  end

  // Counter restarts from zero every time a RAM state is left
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                         r_wait <= '0;
    else if (w_memState && !w_waitDone) r_wait <= r_wait + 3'd1;
    else                                r_wait <= '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:    w_next = ST_FETCH0;
      ST_FETCH0: w_next = bus.stop ? ST_HALTED : ST_FETCH1;
      ST_FETCH1: w_next = w_waitDone ? ST_FETCH2 : ST_FETCH1;
      ST_FETCH2: begin
        if      (w_class == CLS_NOP)  w_next = ST_FETCH0;
        else if (w_class == CLS_HALT) w_next = ST_HALTED;
        else                          w_next = ST_T3;
      end
      ST_T3: begin
        if (w_class == CLS_IO || (w_class == CLS_JUMP && !w_isJal)) w_next = ST_FETCH0;
        else                                                        w_next = ST_T4;
      end
      ST_T4: begin
        if (w_class == CLS_UNARY || w_class == CLS_JUMP) w_next = ST_FETCH0;
        else                                             w_next = ST_T5;
      end
      ST_T5: begin
        if (w_class == CLS_RTYPE || w_class == CLS_ITYPE || (w_class == CLS_MEM && w_isLdi))
          w_next = ST_FETCH0;
        else
          w_next = ST_T6;
      end
      ST_T6: begin
        if (w_class == CLS_MEM) w_next = (w_isLd && !w_waitDone) ? ST_T6 : ST_T7;
        else                    w_next = ST_FETCH0;
      end
      ST_T7:     w_next = (w_isSt && !w_waitDone) ? ST_T7 : ST_FETCH0;
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_RST;
    endcase
  end

  // Control word per step. RST raises dp_clear only once clear is released, so the
  // whole word is zero while reset is held. A stop seen in FETCH0 suppresses the
  // fetch strobes so PC/MAR are left untouched on the way into HALTED.
  always_comb begin
    w_ctl     = '0;
    w_ctl.run = (r_state != ST_RST) && (r_state != ST_HALTED);
    case (r_state)
      ST_RST: w_ctl.dp_clear = clear;
      ST_FETCH0: begin
        if (!bus.stop) begin
          w_ctl.PCout = 1'b1; w_ctl.MARin = 1'b1; w_ctl.IncPC = 1'b1; w_ctl.Zin = 1'b1;
        end
      end
      ST_FETCH1: begin
        w_ctl.Zlowout = 1'b1; w_ctl.PCin = 1'b1; w_ctl.read = 1'b1; w_ctl.MDRin = 1'b1;
      end
      ST_FETCH2: begin
        w_ctl.MDRout = 1'b1; w_ctl.IRin = 1'b1;
      end
      ST_T3: begin
        case (w_class)
          CLS_RTYPE, CLS_ITYPE: begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.Yin = 1'b1; end
          CLS_MEM:    begin w_ctl.Grb = 1'b1; w_ctl.BAout = 1'b1; w_ctl.Yin = 1'b1; end
          CLS_MULDIV: begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.Yin = 1'b1; end
          CLS_UNARY:  begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
          CLS_BR:     begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; end
          CLS_JUMP: begin
            if (w_isJal) begin w_ctl.PCout = 1'b1; w_ctl.Grb = 1'b1; w_ctl.Rin = 1'b1; end
            else         begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.PCin = 1'b1; end
          end
          CLS_IO: begin
            if (w_op == OP_OUT) begin
              w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.OutPort = 1'b1;
            end else begin
              w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
              if      (w_op == OP_IN)   w_ctl.Inportout = 1'b1;
              else if (w_op == OP_MFHI) w_ctl.HIout     = 1'b1;
              else                      w_ctl.LOout     = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_RTYPE:  begin w_ctl.Grc = 1'b1; w_ctl.Rout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
          CLS_ITYPE:  begin w_ctl.Cout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
          CLS_MEM:    begin w_ctl.Cout = 1'b1; w_ctl.alu.add_op = 1'b1; w_ctl.Zin = 1'b1; end
          CLS_MULDIV: begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
          CLS_UNARY:  begin w_ctl.Zlowout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
          CLS_BR:     begin w_ctl.PCout = 1'b1; w_ctl.Yin = 1'b1; end
          CLS_JUMP:   begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CLS_RTYPE, CLS_ITYPE: begin w_ctl.Zlowout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
          CLS_MEM: begin
            w_ctl.Zlowout = 1'b1;
            if (w_isLdi) begin w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
            else         w_ctl.MARin = 1'b1;
          end
          CLS_MULDIV: begin w_ctl.Zlowout = 1'b1; w_ctl.LOin = 1'b1; end
          CLS_BR:     begin w_ctl.Cout = 1'b1; w_ctl.alu.add_op = 1'b1; w_ctl.Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CLS_MEM: begin
            if (w_isLd)      begin w_ctl.read = 1'b1; w_ctl.MDRin = 1'b1; end
            else if (w_isSt) begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.MDRin = 1'b1; end
          end
          CLS_MULDIV: begin w_ctl.Zhighout = 1'b1; w_ctl.HIin = 1'b1; end
          CLS_BR: begin
            if (bus.con_ff) begin w_ctl.Zlowout = 1'b1; w_ctl.PCin = 1'b1; end
          end
          default: ;
        endcase
      end
      ST_T7: begin
        if (w_isLd)      begin w_ctl.MDRout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
        else if (w_isSt) w_ctl.write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.dp_clear  = w_ctl.dp_clear;
  assign bus.run       = w_ctl.run;
  assign bus.PCout     = w_ctl.PCout;
  assign bus.MDRout    = w_ctl.MDRout;
  assign bus.HIout     = w_ctl.HIout;
  assign bus.LOout     = w_ctl.LOout;
  assign bus.Zhighout  = w_ctl.Zhighout;
  assign bus.Zlowout   = w_ctl.Zlowout;
  assign bus.Inportout = w_ctl.Inportout;
  assign bus.Cout      = w_ctl.Cout;
  assign bus.BAout     = w_ctl.BAout;
  assign bus.PCin      = w_ctl.PCin;
  assign bus.IRin      = w_ctl.IRin;
  assign bus.MARin     = w_ctl.MARin;
  assign bus.Yin       = w_ctl.Yin;
  assign bus.HIin      = w_ctl.HIin;
  assign bus.LOin      = w_ctl.LOin;
  assign bus.Zin       = w_ctl.Zin;
  assign bus.MDRin     = w_ctl.MDRin;
  assign bus.Rin       = w_ctl.Rin;
  assign bus.Rout      = w_ctl.Rout;
  assign bus.OutPort   = w_ctl.OutPort;
  assign bus.Gra       = w_ctl.Gra;
  assign bus.Grb       = w_ctl.Grb;
  assign bus.Grc       = w_ctl.Grc;
  assign bus.AND       = w_ctl.alu.and_op;
  assign bus.OR        = w_ctl.alu.or_op;
  assign bus.ADD       = w_ctl.alu.add_op;
  assign bus.SUB       = w_ctl.alu.sub_op;
  assign bus.MUL       = w_ctl.alu.mul_op;
  assign bus.DIV       = w_ctl.alu.div_op;
  assign bus.SHR       = w_ctl.alu.shr_op;
  assign bus.SHL       = w_ctl.alu.shl_op;
  assign bus.ROR       = w_ctl.alu.ror_op;
  assign bus.ROL       = w_ctl.alu.rol_op;
  assign bus.NEG       = w_ctl.alu.neg_op;
  assign bus.NOT       = w_ctl.alu.not_op;
  assign bus.IncPC     = w_ctl.IncPC;
  assign bus.read      = w_ctl.read;
  assign bus.write     = w_ctl.write;

endmodule
